// File: rtl/sample_router.sv
// sample_router: pulls samples from a standard (non-FWFT) FIFO and hands each one to a single sink
// over a shared bus with one-hot enables. Define SAMPLE_ROUTER_HOLD_LAST_EN to re-deliver the last sample on underrun.
module sample_router #(
   parameter int BPS          = 24,
   parameter int NUM_OUT      = 3,
   parameter int SEL_W        = 2,
   parameter int FIFO_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic               in_clk,
   input  logic               in_reset,
   input  logic [SEL_W-1:0]   in_mode,
   input  logic [BPS-1:0]     in_fifo_dout,
   input  logic               in_fifo_empty,
   input  logic               in_fifo_prog_empty,
   output logic               out_fifo_rd_en,
   input  logic [NUM_OUT-1:0] in_sink_ready,
   output logic [BPS-1:0]     out_sample,
   output logic [NUM_OUT-1:0] out_sink_en,
   output logic               out_active,
   output logic [CNT_W-1:0]   out_underrun_cnt
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

   localparam logic [1:0] WAIT_LAST = 2'(FIFO_LATENCY - 1);

   state_t             state;
   logic [SEL_W-1:0]   mode_q;
   logic [1:0]         wait_cnt;
   logic [NUM_OUT-1:0] sel;
   logic               ready_sel;
   logic               mode_ok;
   logic               deliver;

   // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         sel[i] = (int'(mode_q) == i);
      end
   end

   assign ready_sel = |(in_sink_ready & sel);
   assign mode_ok   = int'(in_mode) < NUM_OUT;
   assign deliver   = (state == PRESENT) && ready_sel;

   // The accept pulse is decoded from the state register and the selected ready level so the
   // sink sees it in the very cycle it raises ready; reset forces state to IDLE, clearing it at once.
   assign out_sink_en = deliver ? sel : '0;

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         state            <= IDLE;
         mode_q           <= '0;
         wait_cnt         <= '0;
         out_fifo_rd_en   <= 1'b0;
         out_sample       <= '0;
         out_active       <= 1'b0;
         out_underrun_cnt <= '0;
      end else begin
         out_fifo_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               mode_q <= in_mode;
               if (mode_ok && !in_fifo_prog_empty) begin
                  state          <= FETCH;
                  out_fifo_rd_en <= 1'b1;
                  out_active     <= 1'b1;
               end
            end

            FETCH: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end

            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  out_sample <= in_fifo_dout;
                  state      <= PRESENT;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end

            PRESENT: begin
               if (ready_sel) begin
                  if (in_mode != mode_q) begin
                     // Mode change wins over underrun and is only honoured after the held sample is out.
                     state      <= IDLE;
                     out_active <= 1'b0;
                  end else if (!in_fifo_empty) begin
                     state          <= FETCH;
                     out_fifo_rd_en <= 1'b1;
                  end else begin
                     if (out_underrun_cnt != '1) begin
                        out_underrun_cnt <= out_underrun_cnt + CNT_W'(1);
                     end
`ifdef SAMPLE_ROUTER_HOLD_LAST_EN
                     state <= PRESENT;
`else
                     state      <= IDLE;
                     out_active <= 1'b0;
`endif
                  end
               end
            end

            default: begin
               state      <= IDLE;
               out_active <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_read_when_empty: assert property (@(posedge in_clk) disable iff (in_reset)
      out_fifo_rd_en |-> !in_fifo_empty);
   a_en_onehot: assert property (@(posedge in_clk) disable iff (in_reset)
      $onehot0(out_sink_en));
`endif

endmodule

// File: doc/sample_router.md
Name: sample_router

Overview:
- Parametrised successor to the fixed three-way sample switch.
- Pulls BPS-bit samples from a standard (non-FWFT) FIFO and delivers each sample to exactly one of NUM_OUT sinks (UART serializer, I2S variants, future channels) over a shared sample bus with per-sink one-hot enable.
- Primes on the FIFO programmable-empty watermark, re-latches mode only at safe points, and counts underruns.

Parameters:
- BPS, 24, sample width in bits.
- NUM_OUT, 3, number of sinks (1..8).
- SEL_W, 2, width of in_mode; values >= NUM_OUT mean "disabled".
- FIFO_LATENCY, 1, cycles from rd_en to valid dout (1 or 2).
- CNT_W, 16, underrun counter width.

Ports:
- in_clk  in  1  system clock.
- in_reset  in  1  asynchronous, active-high reset.
- in_mode  in  SEL_W  sink select.
- in_fifo_dout  in  BPS  FIFO read data.
- in_fifo_empty  in  1  FIFO empty.
- in_fifo_prog_empty  in  1  FIFO below start watermark.
- out_fifo_rd_en  out  1  FIFO read strobe, one cycle per sample.
- in_sink_ready  in  NUM_OUT  per-sink "can accept sample" level.
- out_sample  out  BPS  shared sample bus.
- out_sink_en  out  NUM_OUT  one-hot, one-cycle accept pulse.
- out_active  out  1  high while streaming (not IDLE).
- out_underrun_cnt  out  CNT_W  saturating underrun count.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_fifo_rd_en=0; out_sink_en=0; out_sample=0; out_active=0; out_underrun_cnt=0; mode_q=0. Reset mid-transfer abandons the sample; no rd_en or en pulse may be emitted in the release cycle.
- States: IDLE, FETCH, WAIT, PRESENT.
- IDLE:
  - mode_q <= in_mode every cycle.
  - Go to FETCH when in_mode < NUM_OUT and in_fifo_prog_empty=0.
- FETCH:
  - out_fifo_rd_en=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Stay FIFO_LATENCY cycles.
  - On the last cycle, out_sample <= in_fifo_dout.
  - Go to PRESENT.
- PRESENT:
  - out_sample held stable.
  - When in_sink_ready[mode_q]=1: out_sink_en[mode_q]=1 for one cycle, all other bits 0. Then:
    - in_mode != mode_q -> IDLE. No further read; a new mode takes effect only after the in-flight sample is delivered.
    - else in_fifo_empty=0 -> FETCH.
    - else underrun: out_underrun_cnt++ (saturating at all-ones) -> IDLE. Re-prime requires prog_empty=0 again.
  - Ready of non-selected sinks is ignored.
- Latency: prog_empty falls in cycle 0 -> rd_en in cycle 1 -> out_sample valid from cycle 2+FIFO_LATENCY -> earliest en pulse in that cycle. Minimum spacing between successive en pulses is 2+FIFO_LATENCY cycles.
- out_active=1 in FETCH, WAIT and PRESENT.
- out_sample is not cleared on IDLE; it keeps the last delivered value.
- Never asserts rd_en while in_fifo_empty=1.
- in_mode >= NUM_OUT: router stays in IDLE, no reads, no en pulses.
- Simultaneous events: a mode change and an empty FIFO at the same pulse both go to IDLE. The underrun counter increments only if the mode is unchanged.

Optional Feature:
- Macro: SAMPLE_ROUTER_HOLD_LAST_EN.
- Defined: on underrun the router stays in PRESENT and re-delivers the held out_sample on the next in_sink_ready[mode_q], keeping the sink fed.
  - Each repeated delivery increments out_underrun_cnt.
  - Leaves PRESENT for FETCH as soon as in_fifo_empty=0 at a pulse.
  - A mode change still returns to IDLE.
- Undefined: underrun returns to IDLE as described above; no repeats.

Test Plan:
- Prime: FIFO loaded with 0x000001..0x000008, prog_empty drops, mode=1, sink1 ready held high -> eight en[1] pulses carrying 0x000001..0x000008 in order, pulse spacing 3 cycles (FIFO_LATENCY=1), en[0] and en[2] never asserted, rd_en count=8.
- Backpressure: sink1 ready low for 20 cycles after the first fetch -> out_sample stays 0x000001 and no pulse for 20 cycles; pulse occurs in the first cycle ready=1; exactly one rd_en issued meanwhile.
- Underrun: FIFO holds 2 samples, then empty -> 2 pulses, out_underrun_cnt=1, state IDLE; no restart until prog_empty=0. With SAMPLE_ROUTER_HOLD_LAST_EN: 0x000002 re-delivered on each ready and the counter increments per repeat.
- Mode switch: in_mode changes 1->0 while sample 0x0000AA is in PRESENT -> 0x0000AA delivered on en[1]; next sample 0x0000BB delivered on en[0]; no sample lost or duplicated.
- Disabled mode: in_mode=3 with NUM_OUT=3 and FIFO non-empty -> rd_en and out_sink_en stay 0 for 100 cycles.
- Reset: assert in_reset asynchronously in the WAIT state -> all outputs 0 within the same cycle; after release, restart from IDLE with the next FIFO word.
